// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer: generates the game tick, wipes the 16x16 grid one cell per cycle,
// then hands the memory port to the snake writer and flags overrun/draw timeout faults.
module frame_update_sequencer #(
  parameter int          TICK_DIV     = 4194304,
  parameter logic [1:0]  CLEAR_DATA   = 2'b00,
  parameter int          DRAW_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_draw_done,
  output logic        o_game_tick,
  output logic        o_clr_we,
  output logic [3:0]  o_clr_x,
  output logic [3:0]  o_clr_y,
  output logic [1:0]  o_clr_data,
  output logic        o_draw_start,
  output logic        o_busy,
  output logic [15:0] o_frame_count,
  output logic        o_overrun,
  output logic        o_draw_timeout
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = $clog2(DRAW_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW_REQ, DRAW_WAIT} state_t;
  state_t        r_state, w_next;
  logic [TW-1:0] r_tick_cnt;
  logic          r_game_tick;
  logic [7:0]    r_addr;
  logic [WW-1:0] r_wait;
  logic [15:0]   r_frames;
  logic          r_overrun, r_timeout;
  logic          w_tick_wrap, w_done, w_tmo;
  assign w_tick_wrap = r_tick_cnt == TW'(TICK_DIV - 1);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tick_cnt  <= '0;
      r_game_tick <= 1'b0;
    end else begin
      r_game_tick <= i_enable && w_tick_wrap;
      r_tick_cnt  <= (!i_enable || w_tick_wrap) ? '0 : r_tick_cnt + TW'(1);
    end
  end
  // draw_done is only honoured in DRAW_WAIT and beats a coincident timeout
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE:      w_next = r_game_tick ? CLEAR : IDLE;
      CLEAR:     w_next = (r_addr == 8'hFF) ? DRAW_REQ : CLEAR;
      DRAW_REQ:  w_next = DRAW_WAIT;
      DRAW_WAIT: begin
        w_done = i_draw_done;
        w_tmo  = !i_draw_done && (r_wait == WW'(DRAW_TIMEOUT - 1));
        w_next = (w_done || w_tmo) ? IDLE : DRAW_WAIT;
      end
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wait    <= '0;
      r_frames  <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_addr    <= (r_state == CLEAR) ? r_addr + 8'd1 : '0;
      r_wait    <= (r_state == DRAW_WAIT) ? r_wait + WW'(1) : '0;
      r_frames  <= r_frames + {15'd0, w_done};
      r_overrun <= r_overrun || (r_game_tick && r_state != IDLE);
      r_timeout <= r_timeout || w_tmo;
    end
  end
  assign o_game_tick    = r_game_tick;
  assign o_clr_we       = r_state == CLEAR;
  assign o_clr_x        = r_addr[3:0];
  assign o_clr_y        = r_addr[7:4];
  assign o_clr_data     = CLEAR_DATA;
  assign o_draw_start   = r_state == DRAW_REQ;
  assign o_busy         = r_state != IDLE;
  assign o_frame_count  = r_frames;
  assign o_overrun      = r_overrun;
  assign o_draw_timeout = r_timeout;
endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb_frame_update_sequencer: two sequencer instances (slow frame rate and overrunning frame rate)
// checked against vector tables, hand sequences and a frame-position reference model.
module tb_frame_update_sequencer;
  logic clk = 1'b0;
  logic rst, en_a, en_b, dd_a, dd_b;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  typedef struct packed {
    logic        tick, we;
    logic [3:0]  x, y;
    logic [1:0]  data;
    logic        start, busy;
    logic [15:0] fc;
    logic        ovr, tmo;
  } out_t;
  typedef struct {
    int cyc;
    bit tick;
    int pos;
    int fc;
    bit ovr, tmo;
  } mdl_t;
  typedef struct {
    int   cyc;
    bit   inst;
    bit   dd;
    out_t exp;
  } vec_t;
  out_t out_a, out_b;
  mdl_t m[2];
  vec_t vt[$];
  frame_update_sequencer #(.TICK_DIV(400), .CLEAR_DATA(2'b00), .DRAW_TIMEOUT(64)) u_a (
    .i_clk(clk), .i_reset(rst), .i_enable(en_a), .i_draw_done(dd_a),
    .o_game_tick(out_a.tick), .o_clr_we(out_a.we), .o_clr_x(out_a.x), .o_clr_y(out_a.y),
    .o_clr_data(out_a.data), .o_draw_start(out_a.start), .o_busy(out_a.busy),
    .o_frame_count(out_a.fc), .o_overrun(out_a.ovr), .o_draw_timeout(out_a.tmo));
  frame_update_sequencer #(.TICK_DIV(200), .CLEAR_DATA(2'b00), .DRAW_TIMEOUT(16)) u_b (
    .i_clk(clk), .i_reset(rst), .i_enable(en_b), .i_draw_done(dd_b),
    .o_game_tick(out_b.tick), .o_clr_we(out_b.we), .o_clr_x(out_b.x), .o_clr_y(out_b.y),
    .o_clr_data(out_b.data), .o_draw_start(out_b.start), .o_busy(out_b.busy),
    .o_frame_count(out_b.fc), .o_overrun(out_b.ovr), .o_draw_timeout(out_b.tmo));
  function automatic out_t mk(int t, int we, int x, int y, int s, int b, int f, int ov, int tm);
    out_t o;
    o.tick = 1'(t); o.we = 1'(we); o.x = 4'(x); o.y = 4'(y); o.data = 2'b00;
    o.start = 1'(s); o.busy = 1'(b); o.fc = 16'(f); o.ovr = 1'(ov); o.tmo = 1'(tm);
    return o;
  endfunction
  // pos: 0 idle, 1..256 wipe cell pos-1, 257 draw grant, 258.. waiting (wait index pos-258)
  function automatic mdl_t mstep(mdl_t s, bit en, bit dd, int dv, int to);
    mdl_t n;
    n = s;
    n.tick = en && (s.cyc == dv - 1);
    n.cyc  = en ? (s.cyc + 1) % dv : 0;
    n.ovr  = s.ovr || (s.tick && s.pos != 0);
    if (s.pos == 0) n.pos = s.tick ? 1 : 0;
    else if (s.pos <= 257) n.pos = s.pos + 1;
    else if (dd) begin n.pos = 0; n.fc = (s.fc + 1) % 65536; end
    else if (s.pos - 258 == to - 1) begin n.pos = 0; n.tmo = 1'b1; end
    else n.pos = s.pos + 1;
    return n;
  endfunction
  function automatic out_t mexp(mdl_t s);
    bit clr;
    clr = s.pos >= 1 && s.pos <= 256;
    return mk(int'(s.tick), int'(clr), clr ? (s.pos - 1) % 16 : 0, clr ? (s.pos - 1) / 16 : 0,
              int'(s.pos == 257), int'(s.pos != 0), s.fc, int'(s.ovr), int'(s.tmo));
  endfunction
  task automatic check(string name, out_t act, out_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask
  task automatic mreset();
    m[0] = '{default: 0};
    m[1] = '{default: 0};
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) mreset();
    else begin
      m[0] = mstep(m[0], en_a, dd_a, 400, 64);
      m[1] = mstep(m[1], en_b, dd_b, 200, 16);
    end
    #1;
    cyc++;
    dd_a = 1'b0;
    dd_b = 1'b0;
    check("model_a", out_a, mexp(m[0]));
    check("model_b", out_b, mexp(m[1]));
  endtask
  task automatic step_to(int c);
    while (cyc < c) step();
  endtask
  task automatic add(int c, int inst, int dd, out_t e);
    vec_t v;
    v.cyc = c; v.inst = 1'(inst); v.dd = 1'(dd); v.exp = e;
    vt.push_back(v);
  endtask
  initial begin
    add(0,   0, 0, mk(0,0,0,0,0,0,0,0,0));
    add(399, 0, 0, mk(0,0,0,0,0,0,0,0,0));
    add(400, 0, 0, mk(1,0,0,0,0,0,0,0,0));
    add(400, 1, 0, mk(1,1,7,12,0,1,0,0,0));
    add(401, 0, 0, mk(0,1,0,0,0,1,0,0,0));
    add(401, 1, 0, mk(0,1,8,12,0,1,0,1,0));
    add(402, 0, 0, mk(0,1,1,0,0,1,0,0,0));
    add(416, 0, 0, mk(0,1,15,0,0,1,0,0,0));
    add(417, 0, 0, mk(0,1,0,1,0,1,0,0,0));
    add(456, 1, 0, mk(0,1,15,15,0,1,0,1,0));
    add(457, 1, 1, mk(0,0,0,0,1,1,0,1,0));
    add(458, 1, 0, mk(0,0,0,0,0,1,0,1,0));
    add(473, 1, 0, mk(0,0,0,0,0,1,0,1,0));
    add(474, 1, 0, mk(0,0,0,0,0,0,0,1,1));
    add(600, 1, 0, mk(1,0,0,0,0,0,0,1,1));
    add(656, 0, 0, mk(0,1,15,15,0,1,0,0,0));
    add(657, 0, 0, mk(0,0,0,0,1,1,0,0,0));
    add(658, 0, 0, mk(0,0,0,0,0,1,0,0,0));
    add(667, 0, 1, mk(0,0,0,0,0,1,0,0,0));
    add(668, 0, 1, mk(0,0,0,0,0,0,1,0,0));
    add(669, 0, 0, mk(0,0,0,0,0,0,1,0,0));
    add(799, 0, 0, mk(0,0,0,0,0,0,1,0,0));
    add(800, 0, 0, mk(1,0,0,0,0,0,1,0,0));
    add(801, 0, 0, mk(0,1,0,0,0,1,1,0,0));
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; dd_a = 1'b0; dd_b = 1'b0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", out_a, mk(0,0,0,0,0,0,0,0,0));
    check("reset_b", out_b, mk(0,0,0,0,0,0,0,0,0));
    rst = 1'b0; en_a = 1'b1; en_b = 1'b1; cyc = 0;
    foreach (vt[i]) begin
      step_to(vt[i].cyc);
      check(vt[i].inst ? "vec_b" : "vec_a", vt[i].inst ? out_b : out_a, vt[i].exp);
      if (vt[i].dd) begin
        if (vt[i].inst) dd_b = 1'b1;
        else dd_a = 1'b1;
      end
    end
    step_to(854);
    check("pre_reset_a", out_a, mk(0,1,5,3,0,1,1,0,0));
    #2 rst = 1'b1;
    #1;
    mreset();
    check("async_reset_a", out_a, mk(0,0,0,0,0,0,0,0,0));
    check("async_reset_b", out_b, mk(0,0,0,0,0,0,0,0,0));
    repeat (3) step();
    rst = 1'b0; cyc = 0;
    step_to(473);
    check("timeout_edge_b", out_b, mk(0,0,0,0,0,1,0,1,0));
    dd_b = 1'b1;
    step();
    check("done_wins_b", out_b, mk(0,0,0,0,0,0,1,1,0));
    step_to(660);
    check("in_wait_a", out_a, mk(0,0,0,0,0,1,0,0,0));
    en_a = 1'b0;
    step_to(670);
    dd_a = 1'b1;
    step();
    check("done_disabled_a", out_a, mk(0,0,0,0,0,0,1,0,0));
    step_to(800);
    check("no_tick_a", out_a, mk(0,0,0,0,0,0,1,0,0));
    en_a = 1'b1;
    step_to(1199);
    check("pre_reenable_tick_a", out_a, mk(0,0,0,0,0,0,1,0,0));
    step();
    check("reenable_tick_a", out_a, mk(1,0,0,0,0,0,1,0,0));
    for (int i = 0; i < 3000; i++) begin
      rst  = (i >= 1500 && i < 1502);
      dd_a = ($urandom_range(0, 15) == 0);
      dd_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) en_a = ~en_a;
      if ($urandom_range(0, 299) == 0) en_b = ~en_b;
      if (i == 1502) begin en_a = 1'b1; en_b = 1'b1; end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_update_sequencer.md
Name: frame_update_sequencer

Overview:
Sequences each game frame on the shared 16x16 grid memory. It generates the periodic game tick that replaces the free-running slow-clock divider. On every tick it wipes the grid through the software write port, one cell per cycle, then hands the port to the snake writer and waits for it to finish. It sits between the top-level clock and the memory, snake writer and snake logic, and reports overrun and timeout faults.

Parameters:
TICK_DIV, 4194304, clk cycles per game tick (>= 2)
CLEAR_DATA, 2'b00, cell code written during the wipe
DRAW_TIMEOUT, 1024, max cycles to wait for draw_done before abandoning the frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  allows tick generation
draw_done  in  1  single-cycle pulse from the snake writer: redraw complete
game_tick  out  1  single-cycle pulse, advances the snake logic
clr_we  out  1  write enable to the memory software port during the wipe
clr_x  out  4  wipe column address
clr_y  out  4  wipe row address
clr_data  out  2  wipe data, always CLEAR_DATA
draw_start  out  1  single-cycle pulse granting the port to the snake writer
busy  out  1  high whenever state != IDLE
frame_count  out  16  completed frames, wraps 0xFFFF->0
overrun  out  1  sticky: a tick arrived while not IDLE
draw_timeout  out  1  sticky: DRAW_TIMEOUT expired in DRAW_WAIT

Behaviour:
- Reset (async, active-high) forces every output to 0, clr_data excepted, which is always CLEAR_DATA. Reset also clears both counters and the sticky flags, and sets state = IDLE. A reset mid-wipe or mid-draw aborts the frame immediately, with no further writes.
- Tick counter:
  - tick_cnt counts 0..TICK_DIV-1 while enable=1.
  - When enable=0, it is held at 0.
  - game_tick is registered. It is 1 in the cycle after tick_cnt==TICK_DIV-1; tick_cnt wraps to 0 in that same cycle.
  - The first pulse therefore comes TICK_DIV cycles after enable rises, then every TICK_DIV cycles.
- Dropping enable stops further ticks only. A frame already in flight completes.
- FSM states: IDLE, CLEAR, DRAW_REQ, DRAW_WAIT.
- IDLE:
  - game_tick=1 -> CLEAR next cycle, with clr_x=0, clr_y=0.
- CLEAR:
  - clr_we=1 every cycle.
  - Address order is x-major inner loop: x 0..15, then y++.
  - Exactly 256 write cycles.
  - After the cycle with (15,15): clr_we=0 and go to DRAW_REQ. Addresses return to 0.
- DRAW_REQ:
  - draw_start=1 for exactly one cycle, then DRAW_WAIT.
  - draw_done is ignored in this cycle.
- DRAW_WAIT:
  - A wait counter starts at 0 on entry.
  - draw_done=1 -> IDLE next cycle and frame_count++.
  - If the counter reaches DRAW_TIMEOUT-1 without draw_done: go to IDLE, set draw_timeout, leave frame_count unchanged.
  - If draw_done arrives in that same final cycle, done wins: count the frame and do not set the flag.
- A game_tick while state != IDLE:
  - The pulse is still emitted to the snake logic.
  - overrun is set.
  - The tick is not queued, and the FSM does not restart.
- draw_done outside DRAW_WAIT is ignored.
- clr_we is never high outside CLEAR.
- draw_start is never high outside DRAW_REQ.
- Sticky flags clear only on reset.
- Frame latency from tick to draw_start: 1 + 256 cycles. draw_start is in cycle 257 after the game_tick cycle.

Test Plan:
1. TICK_DIV=400, enable=1 from cycle 0 after reset release -> first game_tick in cycle 400; clr_we high cycles 401..656; clr_x/clr_y step (0,0),(1,0)..(15,0),(0,1)..(15,15); draw_start in cycle 657.
2. Continue test 1, pulse draw_done 10 cycles after draw_start -> busy falls next cycle; frame_count=1; no flags set; next tick at cycle 800.
3. TICK_DIV=200, draw_done never asserted, DRAW_TIMEOUT=16 -> second tick lands during CLEAR and sets overrun=1 without restarting the sweep; draw_timeout=1 sixteen cycles after entering DRAW_WAIT; frame_count stays 0.
4. Assert reset mid-CLEAR at clr_x=5, clr_y=3 -> same cycle: clr_we=0, busy=0, addresses 0, frame_count=0; after release, no writes until the next tick.
5. Deassert enable during DRAW_WAIT, then give draw_done -> frame completes, frame_count increments, no further game_tick, tick_cnt held at 0; re-enable -> tick after TICK_DIV cycles.
6. draw_done asserted in the DRAW_REQ cycle and in IDLE -> ignored, no state change; draw_done coinciding with the timeout cycle -> frame counted, draw_timeout stays 0.
